dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared data-memory bus.
- Requester 0 is the core's dmem port; requester 1 is a debug/DMA master.
- Accepts one request at a time with round-robin arbitration and decodes the address to the DMEM or GPIO target.
- Drives the target's op/mask/wdata for one cycle and returns read data, or an error, to the winner after the synchronous-read latency.
- Sits between the requesters and the RAM_Simple/GPIO instances in the tile.

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/dmem_rr_arb2.sv | 52 +++++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (see dmem_rr_arb2).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_MEM  = 2'd1,
    TGT_GPIO = 2'd2
  } tgt_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

  // Region hit test written as an offset compare so base+size never has to be formed
  // and an address below base cannot wrap into a hit.
  function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way arbiter for the data-memory bus. Grants are combinational and only
// produced while en is high. Default build is round-robin, with the pointer holding
// the index of the last winner (reset to 1 so requester 0 wins the first tie).
// Defining DMEM_ARB_FIXED_PRIO_EN makes requester 0 always win and drops the pointer.
module dmem_rr_arb2
  import dmem_arb_pkg::*;
(
`ifndef DMEM_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 1 is served only when requester 0 is idle.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`else
  logic rr_ptr_q, rr_ptr_d;

  // Round-robin grant: on a tie the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_ptr_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt[1])      rr_ptr_d = 1'b1;
    else if (gnt[0]) rr_ptr_d = 1'b0;
  end

  // Pointer register, updated on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b1;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory bus arbiter/sequencer: accepts one request from m0 (core) or m1
// (debug/DMA), decodes DMEM/GPIO, drives the target for one cycle (ACCESS) and
// returns the response pulse in the following cycle (RESP).
// Handshake: a requester holds req (and its fields) until it sees gnt in the same
// cycle; gnt is combinational and only possible in IDLE or RESP; rvalid pulses for
// one cycle two cycles after gnt, with rdata/err valid only alongside it.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (fixed priority to m0).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE   = 32'h08000000,
  parameter logic [31:0] GPIO_BASE   = 32'h10010000,
  parameter logic [31:0] REGION_SIZE = 32'h00001000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_m0_req,
  input  logic [31:0] io_m0_addr,
  input  logic        io_m0_op,
  input  logic [3:0]  io_m0_mask,
  input  logic [31:0] io_m0_wdata,
  output logic        io_m0_gnt,
  output logic        io_m0_rvalid,
  output logic [31:0] io_m0_rdata,
  output logic        io_m0_err,
  input  logic        io_m1_req,
  input  logic [31:0] io_m1_addr,
  input  logic        io_m1_op,
  input  logic [3:0]  io_m1_mask,
  input  logic [31:0] io_m1_wdata,
  output logic        io_m1_gnt,
  output logic        io_m1_rvalid,
  output logic [31:0] io_m1_rdata,
  output logic        io_m1_err,
  output logic [31:0] io_mem_addr,
  output logic        io_mem_op,
  output logic [3:0]  io_mem_mask,
  output logic [31:0] io_mem_wdata,
  input  logic [31:0] io_mem_rdata,
  output logic [31:0] io_gpio_addr,
  output logic        io_gpio_op,
  output logic [3:0]  io_gpio_mask,
  output logic [31:0] io_gpio_wdata,
  input  logic [31:0] io_gpio_rdata
);

  state_e      state_q, state_d;
  logic        id_q, id_d;
  logic        op_q, op_d;
  tgt_e        tgt_q, tgt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] gpio_addr_q, gpio_addr_d, gpio_wdata_q, gpio_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d, gpio_mask_q, gpio_mask_d;
  logic        mem_op_q, mem_op_d, gpio_op_q, gpio_op_d;

  logic [1:0]  gnt;
  logic        arb_en;
  logic [31:0] win_addr, win_wdata, resp_rdata;
  logic [3:0]  win_mask;
  logic        win_op;

  assign arb_en = (state_q == IDLE) || (state_q == RESP);

  dmem_rr_arb2 u_arb (
`ifndef DMEM_ARB_FIXED_PRIO_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req   ({io_m1_req, io_m0_req}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign io_m0_gnt = gnt[0];
  assign io_m1_gnt = gnt[1];

  // Mux the winning requester's fields.
  always_comb begin
    win_addr  = gnt[1] ? io_m1_addr  : io_m0_addr;
    win_op    = gnt[1] ? io_m1_op    : io_m0_op;
    win_mask  = gnt[1] ? io_m1_mask  : io_m0_mask;
    win_wdata = gnt[1] ? io_m1_wdata : io_m0_wdata;
  end

  // Next-state and next-output logic; target outputs default to 0 so they last one cycle.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    op_d         = op_q;
    tgt_d        = tgt_q;
    rvalid_d     = 2'b00;
    err_d        = 1'b0;
    mem_addr_d   = '0;
    mem_op_d     = 1'b0;
    mem_mask_d   = '0;
    mem_wdata_d  = '0;
    gpio_addr_d  = '0;
    gpio_op_d    = 1'b0;
    gpio_mask_d  = '0;
    gpio_wdata_d = '0;
    case (state_q)
      IDLE, RESP: begin
        if (|gnt) begin
          state_d = ACCESS;
          id_d    = gnt[1];
          op_d    = win_op;
          if (in_region(win_addr, DMEM_BASE, REGION_SIZE))      tgt_d = TGT_MEM;
          else if (in_region(win_addr, GPIO_BASE, REGION_SIZE)) tgt_d = TGT_GPIO;
          else                                                  tgt_d = TGT_NONE;
          if (tgt_d == TGT_MEM) begin
            mem_addr_d  = win_addr - DMEM_BASE;
            mem_op_d    = win_op;
            mem_mask_d  = win_mask;
            mem_wdata_d = win_wdata;
          end
          if (tgt_d == TGT_GPIO) begin
            gpio_addr_d  = win_addr - GPIO_BASE;
            gpio_op_d    = win_op;
            gpio_mask_d  = win_mask;
            gpio_wdata_d = win_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (id_q) rvalid_d = 2'b10;
        else      rvalid_d = 2'b01;
        err_d = (tgt_q == TGT_NONE);
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched request and registered target/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      op_q         <= OP_READ;
      tgt_q        <= TGT_NONE;
      rvalid_q     <= 2'b00;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_op_q     <= 1'b0;
      mem_mask_q   <= '0;
      mem_wdata_q  <= '0;
      gpio_addr_q  <= '0;
      gpio_op_q    <= 1'b0;
      gpio_mask_q  <= '0;
      gpio_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      op_q         <= op_d;
      tgt_q        <= tgt_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_op_q     <= mem_op_d;
      mem_mask_q   <= mem_mask_d;
      mem_wdata_q  <= mem_wdata_d;
      gpio_addr_q  <= gpio_addr_d;
      gpio_op_q    <= gpio_op_d;
      gpio_mask_q  <= gpio_mask_d;
      gpio_wdata_q <= gpio_wdata_d;
    end
  end

  // Response data: target read data arrives in RESP, so it is muxed combinationally.
  always_comb begin
    if (err_q)                 resp_rdata = ERR_RDATA;
    else if (op_q == OP_WRITE) resp_rdata = '0;
    else if (tgt_q == TGT_MEM) resp_rdata = io_mem_rdata;
    else                       resp_rdata = io_gpio_rdata;
  end

  assign io_m0_rvalid  = rvalid_q[0];
  assign io_m1_rvalid  = rvalid_q[1];
  assign io_m0_rdata   = rvalid_q[0] ? resp_rdata : '0;
  assign io_m1_rdata   = rvalid_q[1] ? resp_rdata : '0;
  assign io_m0_err     = rvalid_q[0] & err_q;
  assign io_m1_err     = rvalid_q[1] & err_q;
  assign io_mem_addr   = mem_addr_q;
  assign io_mem_op     = mem_op_q;
  assign io_mem_mask   = mem_mask_q;
  assign io_mem_wdata  = mem_wdata_q;
  assign io_gpio_addr  = gpio_addr_q;
  assign io_gpio_op    = gpio_op_q;
  assign io_gpio_mask  = gpio_mask_q;
  assign io_gpio_wdata = gpio_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single transactions to each target and region
// boundaries, contention ordering, and asynchronous reset during ACCESS.
// Honours DMEM_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_dmem_arbiter;

  localparam logic [31:0] MEM_RD  = 32'h12345678;
  localparam logic [31:0] GPIO_RD = 32'h00C0FFEE;
  localparam logic [31:0] JUNK    = 32'hFFFF0000;

  logic        clk, rst_n;
  logic        io_m0_req, io_m0_op, io_m0_gnt, io_m0_rvalid, io_m0_err;
  logic [31:0] io_m0_addr, io_m0_wdata, io_m0_rdata;
  logic [3:0]  io_m0_mask;
  logic        io_m1_req, io_m1_op, io_m1_gnt, io_m1_rvalid, io_m1_err;
  logic [31:0] io_m1_addr, io_m1_wdata, io_m1_rdata;
  logic [3:0]  io_m1_mask;
  logic [31:0] io_mem_addr, io_mem_wdata, io_mem_rdata;
  logic        io_mem_op;
  logic [3:0]  io_mem_mask;
  logic [31:0] io_gpio_addr, io_gpio_wdata, io_gpio_rdata;
  logic        io_gpio_op;
  logic [3:0]  io_gpio_mask;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .io_m0_req(io_m0_req), .io_m0_addr(io_m0_addr), .io_m0_op(io_m0_op),
    .io_m0_mask(io_m0_mask), .io_m0_wdata(io_m0_wdata), .io_m0_gnt(io_m0_gnt),
    .io_m0_rvalid(io_m0_rvalid), .io_m0_rdata(io_m0_rdata), .io_m0_err(io_m0_err),
    .io_m1_req(io_m1_req), .io_m1_addr(io_m1_addr), .io_m1_op(io_m1_op),
    .io_m1_mask(io_m1_mask), .io_m1_wdata(io_m1_wdata), .io_m1_gnt(io_m1_gnt),
    .io_m1_rvalid(io_m1_rvalid), .io_m1_rdata(io_m1_rdata), .io_m1_err(io_m1_err),
    .io_mem_addr(io_mem_addr), .io_mem_op(io_mem_op), .io_mem_mask(io_mem_mask),
    .io_mem_wdata(io_mem_wdata), .io_mem_rdata(io_mem_rdata),
    .io_gpio_addr(io_gpio_addr), .io_gpio_op(io_gpio_op), .io_gpio_mask(io_gpio_mask),
    .io_gpio_wdata(io_gpio_wdata), .io_gpio_rdata(io_gpio_rdata)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    io_m0_req = 1'b0; io_m0_addr = '0; io_m0_op = 1'b0; io_m0_mask = '0; io_m0_wdata = '0;
    io_m1_req = 1'b0; io_m1_addr = '0; io_m1_op = 1'b0; io_m1_mask = '0; io_m1_wdata = '0;
  endtask

  task automatic drive_req(input int id, input logic [31:0] addr, input logic op,
                           input logic [3:0] mask, input logic [31:0] wdata);
    if (id == 0) begin
      io_m0_req = 1'b1; io_m0_addr = addr; io_m0_op = op; io_m0_mask = mask; io_m0_wdata = wdata;
    end else begin
      io_m1_req = 1'b1; io_m1_addr = addr; io_m1_op = op; io_m1_mask = mask; io_m1_wdata = wdata;
    end
  endtask

  // Reset with checks of the reset values while rst_n is low.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    io_mem_rdata = MEM_RD;
    io_gpio_rdata = GPIO_RD;
    tick();
    @(negedge clk);
    chk("rst_gnt", {30'd0, io_m1_gnt, io_m0_gnt}, 32'd0);
    chk("rst_rvalid_err", {28'd0, io_m1_rvalid, io_m0_rvalid, io_m1_err, io_m0_err}, 32'd0);
    chk("rst_ops", {30'd0, io_gpio_op, io_mem_op}, 32'd0);
    chk("rst_addr", io_mem_addr | io_gpio_addr, 32'd0);
    chk("rst_data", io_mem_wdata | io_gpio_wdata | io_m0_rdata | io_m1_rdata, 32'd0);
    chk("rst_mask", {24'd0, io_gpio_mask, io_mem_mask}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated transaction. tgt: 0 = miss, 1 = DMEM, 2 = GPIO; off = expected target offset.
  task automatic txn(input string nm, input int id, input logic [31:0] addr, input logic op,
                     input logic [3:0] mask, input logic [31:0] wdata, input int tgt,
                     input logic [31:0] off);
    logic [31:0] exp_rd;
    logic        g_w, g_o, rv_w, rv_o;
    logic [31:0] rd_w;
    if (tgt == 0)      exp_rd = 32'hDEADBEEF;
    else if (op)       exp_rd = 32'd0;
    else if (tgt == 1) exp_rd = MEM_RD;
    else               exp_rd = GPIO_RD;
    tick();
    drive_req(id, addr, op, mask, wdata);
    @(negedge clk);
    g_w = (id == 0) ? io_m0_gnt : io_m1_gnt;
    g_o = (id == 0) ? io_m1_gnt : io_m0_gnt;
    chk({nm, "_gnt"}, {31'd0, g_w}, 32'd1);
    chk({nm, "_gnt_other"}, {31'd0, g_o}, 32'd0);
    tick();
    clear_reqs();
    io_mem_rdata = JUNK;
    io_gpio_rdata = JUNK;
    @(negedge clk);
    chk({nm, "_mem_op"}, {31'd0, io_mem_op}, (tgt == 1) ? {31'd0, op} : 32'd0);
    chk({nm, "_mem_addr"}, io_mem_addr, (tgt == 1) ? off : 32'd0);
    chk({nm, "_mem_mask"}, {28'd0, io_mem_mask}, (tgt == 1) ? {28'd0, mask} : 32'd0);
    chk({nm, "_mem_wdata"}, io_mem_wdata, (tgt == 1) ? wdata : 32'd0);
    chk({nm, "_gpio_op"}, {31'd0, io_gpio_op}, (tgt == 2) ? {31'd0, op} : 32'd0);
    chk({nm, "_gpio_addr"}, io_gpio_addr, (tgt == 2) ? off : 32'd0);
    chk({nm, "_gpio_mask"}, {28'd0, io_gpio_mask}, (tgt == 2) ? {28'd0, mask} : 32'd0);
    chk({nm, "_gpio_wdata"}, io_gpio_wdata, (tgt == 2) ? wdata : 32'd0);
    chk({nm, "_acc_rvalid"}, {30'd0, io_m1_rvalid, io_m0_rvalid}, 32'd0);
    chk({nm, "_acc_gnt"}, {30'd0, io_m1_gnt, io_m0_gnt}, 32'd0);
    tick();
    io_mem_rdata = MEM_RD;
    io_gpio_rdata = GPIO_RD;
    @(negedge clk);
    rv_w = (id == 0) ? io_m0_rvalid : io_m1_rvalid;
    rv_o = (id == 0) ? io_m1_rvalid : io_m0_rvalid;
    rd_w = (id == 0) ? io_m0_rdata  : io_m1_rdata;
    chk({nm, "_rvalid"}, {31'd0, rv_w}, 32'd1);
    chk({nm, "_rvalid_other"}, {31'd0, rv_o}, 32'd0);
    chk({nm, "_rdata"}, rd_w, exp_rd);
    chk({nm, "_err"}, {31'd0, (id == 0) ? io_m0_err : io_m1_err}, (tgt == 0) ? 32'd1 : 32'd0);
    chk({nm, "_resp_ops"}, {30'd0, io_gpio_op, io_mem_op}, 32'd0);
    tick();
    @(negedge clk);
    chk({nm, "_idle_rvalid"}, {30'd0, io_m1_rvalid, io_m0_rvalid}, 32'd0);
  endtask

  // Expected per contention cycle: {gnt0, gnt1, rvalid0, rvalid1}.
  logic [3:0] cont_exp [6];

  initial begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    cont_exp = '{4'b1000, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b0000};
`else
    cont_exp = '{4'b1000, 4'b0000, 4'b0110, 4'b0000, 4'b1001, 4'b0000};
`endif
    do_reset();

    txn("rd_mem",     0, 32'h08000010, 1'b0, 4'b1111, 32'h0,        1, 32'h00000010);
    txn("wr_gpio",    1, 32'h10010000, 1'b1, 4'b0011, 32'h000000A5, 2, 32'h00000000);
    txn("miss_top",   0, 32'h08001000, 1'b0, 4'b1111, 32'h0,        0, 32'h0);
    txn("mem_last",   1, 32'h08000FFF, 1'b1, 4'b0000, 32'h000055AA, 1, 32'h00000FFF);
    txn("below_base", 0, 32'h07FFFFFF, 1'b0, 4'b1111, 32'h0,        0, 32'h0);
    txn("gpio_last",  1, 32'h10010FFC, 1'b0, 4'b1111, 32'h0,        2, 32'h00000FFC);
    txn("gpio_miss",  1, 32'h10011000, 1'b1, 4'b1111, 32'h11223344, 0, 32'h0);

    // Contention: both requesters held high from the first cycle after reset.
    do_reset();
    tick();
    drive_req(0, 32'h08000004, 1'b0, 4'b1111, 32'h0);
    drive_req(1, 32'h10010008, 1'b0, 4'b1111, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_gnt0", c), {31'd0, io_m0_gnt}, {31'd0, cont_exp[c][3]});
      chk($sformatf("cont%0d_gnt1", c), {31'd0, io_m1_gnt}, {31'd0, cont_exp[c][2]});
      chk($sformatf("cont%0d_rv0", c), {31'd0, io_m0_rvalid}, {31'd0, cont_exp[c][1]});
      chk($sformatf("cont%0d_rv1", c), {31'd0, io_m1_rvalid}, {31'd0, cont_exp[c][0]});
      if (cont_exp[c][1]) chk($sformatf("cont%0d_rd0", c), io_m0_rdata, MEM_RD);
      if (cont_exp[c][0]) chk($sformatf("cont%0d_rd1", c), io_m1_rdata, GPIO_RD);
      tick();
    end
    clear_reqs();
    @(negedge clk);
    chk("cont6_rv0", {31'd0, io_m0_rvalid}, 32'd1);
    chk("cont6_rd0", io_m0_rdata, MEM_RD);
    chk("cont6_rv1", {31'd0, io_m1_rvalid}, 32'd0);
    tick();

    // Asynchronous reset in the middle of an ACCESS cycle.
    do_reset();
    tick();
    drive_req(1, 32'h10010004, 1'b1, 4'b1111, 32'h0000CAFE);
    @(negedge clk);
    chk("ar_gnt1", {31'd0, io_m1_gnt}, 32'd1);
    tick();
    clear_reqs();
    #1;
    chk("ar_gpio_op_before", {31'd0, io_gpio_op}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_gpio_op_drop", {31'd0, io_gpio_op}, 32'd0);
    chk("ar_mem_op_drop", {31'd0, io_mem_op}, 32'd0);
    chk("ar_gpio_addr_drop", io_gpio_addr, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_no_rvalid_a", {30'd0, io_m1_rvalid, io_m0_rvalid}, 32'd0);
    tick();
    @(negedge clk);
    chk("ar_no_rvalid_b", {30'd0, io_m1_rvalid, io_m0_rvalid}, 32'd0);
    tick();
    drive_req(0, 32'h08000000, 1'b0, 4'b1111, 32'h0);
    drive_req(1, 32'h10010000, 1'b0, 4'b1111, 32'h0);
    @(negedge clk);
    chk("ar_tie_gnt0", {31'd0, io_m0_gnt}, 32'd1);
    chk("ar_tie_gnt1", {31'd0, io_m1_gnt}, 32'd0);
    tick();
    clear_reqs();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
